// File: rtl/alu_exec_pkg.sv
// Shared types for the execute-stage ALU: the machine word, the ALU_CTRL_*
// operation codes (common with alu_ctrl_gen), the FSM state enum and the
// single-cycle ALU function.
package alu_exec_pkg;

  typedef logic [31:0] word_t;

  localparam word_t ALU_CTRL_ADD  = 32'h0000_0000;
  localparam word_t ALU_CTRL_SUB  = 32'h0000_0001;
  localparam word_t ALU_CTRL_XOR  = 32'h0000_0002;
  localparam word_t ALU_CTRL_OR   = 32'h0000_0003;
  localparam word_t ALU_CTRL_AND  = 32'h0000_0004;
  localparam word_t ALU_CTRL_SLL  = 32'h0000_0005;
  localparam word_t ALU_CTRL_SRL  = 32'h0000_0006;
  localparam word_t ALU_CTRL_SRA  = 32'h0000_0007;
  localparam word_t ALU_CTRL_SEQ  = 32'h0000_0008;
  localparam word_t ALU_CTRL_SLT  = 32'h0000_0009;
  localparam word_t ALU_CTRL_SGE  = 32'h0000_000A;
  localparam word_t ALU_CTRL_SLTU = 32'h0000_000B;
  localparam word_t ALU_CTRL_SGEU = 32'h0000_000C;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_exec_state_t;

  typedef enum logic [1:0] {
    SHK_SLL = 2'd0,
    SHK_SRL = 2'd1,
    SHK_SRA = 2'd2
  } shift_kind_t;

  function automatic logic is_shift_op(word_t ctrl);
    return (ctrl == ALU_CTRL_SLL) || (ctrl == ALU_CTRL_SRL) || (ctrl == ALU_CTRL_SRA);
  endfunction

  // Shift ops return op_a here: this path is only taken for a zero shift amount.
  function automatic word_t alu_single(word_t ctrl, word_t a, word_t b);
    word_t r;
    case (ctrl)
      ALU_CTRL_ADD:  r = a + b;
      ALU_CTRL_SUB:  r = a - b;
      ALU_CTRL_XOR:  r = a ^ b;
      ALU_CTRL_OR:   r = a | b;
      ALU_CTRL_AND:  r = a & b;
      ALU_CTRL_SLL,
      ALU_CTRL_SRL,
      ALU_CTRL_SRA:  r = a;
      ALU_CTRL_SEQ:  r = {31'd0, (a == b)};
      ALU_CTRL_SLT:  r = {31'd0, ($signed(a) <  $signed(b))};
      ALU_CTRL_SGE:  r = {31'd0, ($signed(a) >= $signed(b))};
      ALU_CTRL_SLTU: r = {31'd0, (a <  b)};
      ALU_CTRL_SGEU: r = {31'd0, (a >= b)};
      default:       r = 32'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Operand/result handshake bundle between the issue logic and alu_exec.
interface alu_exec_if;

  logic                in_valid;
  logic                in_ready;
  alu_exec_pkg::word_t alu_ctrl;
  alu_exec_pkg::word_t op_a;
  alu_exec_pkg::word_t op_b;
  logic                out_valid;
  logic                out_ready;
  alu_exec_pkg::word_t result;

  modport master (
    output in_valid, alu_ctrl, op_a, op_b, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, alu_ctrl, op_a, op_b, out_ready,
    output in_ready, out_valid, result
  );

endinterface

// File: rtl/alu_exec_shift.sv
// Iterative shifter: moves the operand by at most SHIFT_STEP bits per cycle
// so no full barrel shifter sits in the execute path. 'done' is high in the
// cycle that performs the final step; 'next_value' is the value after it.
module alu_shift_unit
  import alu_exec_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        kill,
  input  logic        start,
  input  shift_kind_t kind,
  input  word_t       value,
  input  logic [4:0]  shamt,
  output logic        busy,
  output logic        done,
  output word_t       next_value
);

  localparam logic [5:0] STEP_W = 6'(SHIFT_STEP);

  word_t       shreg_r;
  logic [5:0]  rem_r;
  shift_kind_t kind_r;
  logic [5:0]  step_s;
  word_t       shifted_s;

  // One shift step of min(SHIFT_STEP, remaining) in the captured direction.
  always_comb begin
    step_s    = 6'd0;
    shifted_s = shreg_r;
    if (rem_r > STEP_W) begin
      step_s = STEP_W;
    end else begin
      step_s = rem_r;
    end
    case (kind_r)
      SHK_SLL: shifted_s = shreg_r << step_s;
      SHK_SRL: shifted_s = shreg_r >> step_s;
      SHK_SRA: shifted_s = word_t'($signed(shreg_r) >>> step_s);
      default: shifted_s = shreg_r;
    endcase
  end

  assign busy       = (rem_r != 6'd0);
  assign done       = (rem_r != 6'd0) && (rem_r <= STEP_W);
  assign next_value = shifted_s;

  // Shift register and remaining count; kill drops any partial shift.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_r <= 32'd0;
      rem_r   <= 6'd0;
      kind_r  <= SHK_SLL;
    end else if (kill) begin
      shreg_r <= 32'd0;
      rem_r   <= 6'd0;
      kind_r  <= SHK_SLL;
    end else if (start) begin
      shreg_r <= value;
      rem_r   <= {1'b0, shamt};
      kind_r  <= kind;
    end else if (rem_r != 6'd0) begin
      shreg_r <= shifted_s;
      rem_r   <= rem_r - step_s;
    end else begin
      shreg_r <= shreg_r;
      rem_r   <= rem_r;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle ops complete with latency 1, shifts by a
// non-zero amount go through alu_shift_unit. Result is registered and held
// under backpressure; DONE can accept a new op in the same cycle its result
// is taken, giving one op per cycle for single-cycle ops.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  alu_exec_if.slave  bus
);

  alu_exec_state_t state_r;
  alu_exec_state_t next_state_s;
  word_t           result_r;
  logic            out_valid_r;
  logic            in_ready_s;
  logic            accept_s;
  logic            go_shift_s;
  logic            sh_start_s;
  logic            load_alu_s;
  logic            load_shift_s;
  shift_kind_t     kind_s;
  word_t           alu_res_s;
  logic            sh_busy_s;
  logic            sh_done_s;
  word_t           sh_next_s;

  assign accept_s   = bus.in_valid && in_ready_s;
  assign go_shift_s = is_shift_op(bus.alu_ctrl) && (bus.op_b[4:0] != 5'd0);
  assign alu_res_s  = alu_single(bus.alu_ctrl, bus.op_a, bus.op_b);

  // Map the shift opcode onto the shifter's direction/arith selector.
  always_comb begin
    kind_s = SHK_SLL;
    case (bus.alu_ctrl)
      ALU_CTRL_SLL: kind_s = SHK_SLL;
      ALU_CTRL_SRL: kind_s = SHK_SRL;
      ALU_CTRL_SRA: kind_s = SHK_SRA;
      default:      kind_s = SHK_SLL;
    endcase
  end

  // Ready: free in IDLE, pass-through of out_ready in DONE, never while flushing.
  always_comb begin
    in_ready_s = 1'b0;
    if (flush) begin
      in_ready_s = 1'b0;
    end else begin
      case (state_r)
        IDLE:    in_ready_s = 1'b1;
        DONE:    in_ready_s = bus.out_ready;
        default: in_ready_s = 1'b0;
      endcase
    end
  end

  // Next-state and datapath load strobes; flush abandons everything.
  always_comb begin
    next_state_s = state_r;
    sh_start_s   = 1'b0;
    load_alu_s   = 1'b0;
    load_shift_s = 1'b0;
    if (flush) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            if (go_shift_s) begin
              next_state_s = SHIFT;
              sh_start_s   = 1'b1;
            end else begin
              next_state_s = DONE;
              load_alu_s   = 1'b1;
            end
          end else if ((state_r == DONE) && !bus.out_ready) begin
            next_state_s = DONE;
          end else begin
            next_state_s = IDLE;
          end
        end
        SHIFT: begin
          if (sh_done_s) begin
            next_state_s = DONE;
            load_shift_s = 1'b1;
          end else begin
            next_state_s = SHIFT;
          end
        end
        default: next_state_s = IDLE;
      endcase
    end
  end

  // State, output-valid and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      result_r    <= 32'd0;
    end else begin
      state_r     <= next_state_s;
      out_valid_r <= (next_state_s == DONE);
      if (load_alu_s) begin
        result_r <= alu_res_s;
      end else if (load_shift_s) begin
        result_r <= sh_next_s;
      end else begin
        result_r <= result_r;
      end
    end
  end

  alu_shift_unit #(
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shift (
    .clk        (clk),
    .rst_n      (rst_n),
    .kill       (flush),
    .start      (sh_start_s),
    .kind       (kind_s),
    .value      (bus.op_a),
    .shamt      (bus.op_b[4:0]),
    .busy       (sh_busy_s),
    .done       (sh_done_s),
    .next_value (sh_next_s)
  );

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: one instance with SHIFT_STEP=1 and one with SHIFT_STEP=4,
// each watched every cycle by a latency/result model, plus directed vectors.
module tb_alu_exec;
  import alu_exec_pkg::*;

  logic  clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst_d [2];
  logic  flush_d [2];
  logic  iv [2];
  word_t ctl [2];
  word_t a_d [2];
  word_t b_d [2];
  logic  ordy [2];
  logic  iready [2];
  logic  ovalid [2];
  word_t res [2];

  int n_checks = 0;
  int n_pass   = 0;

  alu_exec_if bus0 ();
  alu_exec_if bus1 ();

  assign bus0.in_valid  = iv[0];
  assign bus0.alu_ctrl  = ctl[0];
  assign bus0.op_a      = a_d[0];
  assign bus0.op_b      = b_d[0];
  assign bus0.out_ready = ordy[0];
  assign iready[0]      = bus0.in_ready;
  assign ovalid[0]      = bus0.out_valid;
  assign res[0]         = bus0.result;

  assign bus1.in_valid  = iv[1];
  assign bus1.alu_ctrl  = ctl[1];
  assign bus1.op_a      = a_d[1];
  assign bus1.op_b      = b_d[1];
  assign bus1.out_ready = ordy[1];
  assign iready[1]      = bus1.in_ready;
  assign ovalid[1]      = bus1.out_valid;
  assign res[1]         = bus1.result;

  alu_exec #(.SHIFT_STEP(1)) dut0 (.clk(clk), .rst_n(rst_d[0]), .flush(flush_d[0]), .bus(bus0));
  alu_exec #(.SHIFT_STEP(4)) dut1 (.clk(clk), .rst_n(rst_d[1]), .flush(flush_d[1]), .bus(bus1));

  task automatic check(string name, word_t act, word_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_bit(string name, logic act, logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  function automatic word_t model_result(word_t c, word_t a, word_t b);
    int sh;
    sh = int'(b[4:0]);
    if (c == ALU_CTRL_ADD)  return a + b;
    if (c == ALU_CTRL_SUB)  return a - b;
    if (c == ALU_CTRL_XOR)  return a ^ b;
    if (c == ALU_CTRL_OR)   return a | b;
    if (c == ALU_CTRL_AND)  return a & b;
    if (c == ALU_CTRL_SLL)  return a << sh;
    if (c == ALU_CTRL_SRL)  return a >> sh;
    if (c == ALU_CTRL_SRA)  return word_t'($signed(a) >>> sh);
    if (c == ALU_CTRL_SEQ)  return (a == b) ? 32'd1 : 32'd0;
    if (c == ALU_CTRL_SLT)  return ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
    if (c == ALU_CTRL_SGE)  return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
    if (c == ALU_CTRL_SLTU) return (a <  b) ? 32'd1 : 32'd0;
    if (c == ALU_CTRL_SGEU) return (a >= b) ? 32'd1 : 32'd0;
    return 32'd0;
  endfunction

  function automatic int model_lat(word_t c, word_t b, int step);
    int sh;
    sh = int'(b[4:0]);
    if ((c == ALU_CTRL_SLL || c == ALU_CTRL_SRL || c == ALU_CTRL_SRA) && sh > 0)
      return 1 + (sh + step - 1) / step;
    return 1;
  endfunction

  logic  m_init [2] = '{1'b0, 1'b0};
  logic  m_valid [2];
  word_t m_res [2];
  word_t m_pend [2];
  int    m_cnt [2];

  // Per-cycle compare against the model, then advance the model over the coming edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic exp_ir;
      int   stp;
      stp    = (k == 0) ? 1 : 4;
      exp_ir = !flush_d[k] && (m_cnt[k] == 0) && (!m_valid[k] || ordy[k]);
      if (m_init[k]) begin
        check_bit($sformatf("model_in_ready[%0d]", k), iready[k], exp_ir);
        check_bit($sformatf("model_out_valid[%0d]", k), ovalid[k], m_valid[k]);
        if (m_valid[k]) check($sformatf("model_result[%0d]", k), res[k], m_res[k]);
      end
      if (!rst_d[k]) begin
        m_init[k]  = 1'b1;
        m_valid[k] = 1'b0;
        m_cnt[k]   = 0;
        m_res[k]   = 32'd0;
      end else if (flush_d[k]) begin
        m_valid[k] = 1'b0;
        m_cnt[k]   = 0;
      end else begin
        if (m_valid[k] && ordy[k]) m_valid[k] = 1'b0;
        if (iv[k] && exp_ir) begin
          m_pend[k] = model_result(ctl[k], a_d[k], b_d[k]);
          m_cnt[k]  = model_lat(ctl[k], b_d[k], stp);
        end
        if (m_cnt[k] > 0) begin
          m_cnt[k]--;
          if (m_cnt[k] == 0) begin
            m_valid[k] = 1'b1;
            m_res[k]   = m_pend[k];
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic issue(int k, word_t c, word_t a, word_t b);
    logic got;
    got    = 1'b0;
    iv[k]  = 1'b1;
    ctl[k] = c;
    a_d[k] = a;
    b_d[k] = b;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = iready[k];
      @(posedge clk);
      #1;
    end
    iv[k] = 1'b0;
    if (!got) check_bit("issue_timeout", got, 1'b1);
  endtask

  task automatic run_op(int k, string nm, word_t c, word_t a, word_t b, word_t exp, int exp_lat);
    int lat;
    lat = 0;
    issue(k, c, a, b);
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (ovalid[k]) begin
        lat = i;
        break;
      end
      if (exp_lat > 1) check_bit({nm, "_busy_in_ready"}, iready[k], 1'b0);
    end
    check({nm, "_res"}, res[k], exp);
    check({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t exp_seq [4];
    int    nv;
    exp_seq = '{32'd3, 32'd11, 32'd22, 32'd33};
    for (int k = 0; k < 2; k++) begin
      rst_d[k] = 1'b0; flush_d[k] = 1'b0; iv[k] = 1'b0; ordy[k] = 1'b1;
      ctl[k] = 32'd0; a_d[k] = 32'd0; b_d[k] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_d[0] = 1'b1;
    rst_d[1] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_bit("reset_in_ready", iready[k], 1'b1);
      check_bit("reset_out_valid", ovalid[k], 1'b0);
      check("reset_result", res[k], 32'd0);
    end
    @(posedge clk);
    #1;

    run_op(0, "add_wrap", ALU_CTRL_ADD, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1);
    run_op(0, "slt",  ALU_CTRL_SLT,  32'hFFFF_FFFE, 32'd1, 32'd1, 1);
    run_op(0, "sltu", ALU_CTRL_SLTU, 32'hFFFF_FFFE, 32'd1, 32'd0, 1);
    run_op(0, "sra4_s1", ALU_CTRL_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 5);
    run_op(0, "sll32", ALU_CTRL_SLL, 32'h1234_5678, 32'd32, 32'h1234_5678, 1);
    run_op(0, "srl31_s1", ALU_CTRL_SRL, 32'h8000_0000, 32'd31, 32'h0000_0001, 32);
    run_op(0, "sub", ALU_CTRL_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
    run_op(0, "xor", ALU_CTRL_XOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 1);
    run_op(0, "or",  ALU_CTRL_OR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 1);
    run_op(0, "and", ALU_CTRL_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1);
    run_op(0, "seq", ALU_CTRL_SEQ, 32'd5, 32'd5, 32'd1, 1);
    run_op(0, "sge", ALU_CTRL_SGE, 32'h8000_0000, 32'd1, 32'd0, 1);
    run_op(0, "sgeu", ALU_CTRL_SGEU, 32'h8000_0000, 32'd1, 32'd1, 1);
    run_op(0, "unknown", 32'h0000_00FF, 32'h1234_5678, 32'd9, 32'd0, 1);

    // Backpressure: result held, nothing accepted, then three back-to-back ADDs.
    ordy[0] = 1'b0;
    issue(0, ALU_CTRL_ADD, 32'd1, 32'd2);
    iv[0] = 1'b1; ctl[0] = ALU_CTRL_ADD; a_d[0] = 32'd100; b_d[0] = 32'd100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_bit("bp_out_valid", ovalid[0], 1'b1);
      check("bp_result", res[0], 32'd3);
      check_bit("bp_in_ready", iready[0], 1'b0);
      @(posedge clk);
      #1;
    end
    ordy[0] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      a_d[0] = 32'(10 * (j + 1));
      b_d[0] = 32'(j + 1);
      @(negedge clk);
      check_bit("b2b_in_ready", iready[0], 1'b1);
      check_bit("b2b_out_valid", ovalid[0], 1'b1);
      check("b2b_result", res[0], exp_seq[j]);
      @(posedge clk);
      #1;
    end
    iv[0] = 1'b0;
    @(negedge clk);
    check_bit("b2b_last_valid", ovalid[0], 1'b1);
    check("b2b_last_result", res[0], exp_seq[3]);
    @(posedge clk);
    #1;

    // Flush together with in_valid while idle: nothing accepted.
    iv[0] = 1'b1; ctl[0] = ALU_CTRL_ADD; a_d[0] = 32'd4; b_d[0] = 32'd5;
    flush_d[0] = 1'b1;
    @(negedge clk);
    check_bit("flush_idle_in_ready", iready[0], 1'b0);
    @(posedge clk);
    #1;
    flush_d[0] = 1'b0;
    iv[0] = 1'b0;
    @(negedge clk);
    check_bit("flush_idle_no_valid", ovalid[0], 1'b0);
    @(posedge clk);
    #1;

    // Flush mid-shift: partial shift discarded, no result ever appears.
    issue(0, ALU_CTRL_SLL, 32'd1, 32'd20);
    repeat (3) @(posedge clk);
    #1;
    flush_d[0] = 1'b1;
    @(posedge clk);
    #1;
    flush_d[0] = 1'b0;
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ovalid[0]) nv++;
    end
    check("flush_shift_no_result", 32'(nv), 32'd0);
    @(posedge clk);
    #1;
    run_op(0, "srl_after_flush", ALU_CTRL_SRL, 32'h0000_0100, 32'd4, 32'h0000_0010, 5);

    // Reset mid-shift for one cycle, then a normal op.
    issue(0, ALU_CTRL_SRL, 32'hF000_0000, 32'd16);
    repeat (3) @(posedge clk);
    #1;
    rst_d[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_d[0] = 1'b1;
    @(negedge clk);
    check_bit("rst_mid_out_valid", ovalid[0], 1'b0);
    check("rst_mid_result", res[0], 32'd0);
    check_bit("rst_mid_in_ready", iready[0], 1'b1);
    @(posedge clk);
    #1;
    run_op(0, "add_after_rst", ALU_CTRL_ADD, 32'd7, 32'd8, 32'd15, 1);

    // SHIFT_STEP = 4 instance.
    run_op(1, "sra4_s4", ALU_CTRL_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 2);
    run_op(1, "srl31_s4", ALU_CTRL_SRL, 32'h8000_0000, 32'd31, 32'h0000_0001, 9);
    run_op(1, "sll5_s4", ALU_CTRL_SLL, 32'h0000_0001, 32'd5, 32'h0000_0020, 3);
    run_op(1, "sll32_s4", ALU_CTRL_SLL, 32'hCAFE_0001, 32'd32, 32'hCAFE_0001, 1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
